// File: rtl/bcd_entry.sv
// bcd_entry: keypad-style entry of up to seven BCD digits for a display.
// Digits shift in from the right. Backspace shifts them back out, clear
// blanks the display, and commit captures the entry and holds it on the
// display for HOLD_CYCLES cycles. Refused strobes raise a one-cycle reject
// pulse. All outputs are registered.
module bcd_entry #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_digit_valid,
  input  logic [3:0]  i_digit,
  input  logic        i_backspace,
  input  logic        i_clear,
  input  logic        i_commit,
  output logic [27:0] o_code,
  output logic [2:0]  o_count,
  output logic        o_full,
  output logic        o_reject,
  output logic        o_commit_valid,
  output logic [27:0] o_committed_code
);

  localparam int             TW    = $clog2(HOLD_CYCLES) + 1;
  localparam logic [TW-1:0]  LAST  = TW'(HOLD_CYCLES - 1);
  localparam logic [27:0]    BLANK = 28'hAAAAAAA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [27:0]   r_code;
  logic [2:0]    r_count;
  logic          r_full;
  logic          r_reject;
  logic          r_commit_valid;
  logic [27:0]   r_committed_code;
  logic [TW-1:0] r_timer;

  state_t        w_state_next;
  logic [27:0]   w_code_next;
  logic [2:0]    w_count_next;
  logic          w_reject_next;
  logic          w_commit_valid_next;
  logic [27:0]   w_committed_next;
  logic [TW-1:0] w_timer_next;

  // Only the highest-priority strobe in a cycle is considered at all.
  logic w_sel_clear;
  logic w_sel_commit;
  logic w_sel_bs;
  logic w_sel_digit;
  logic w_expired;

  assign w_sel_clear  = i_clear;
  assign w_sel_commit = !i_clear && i_commit;
  assign w_sel_bs     = !i_clear && !i_commit && i_backspace;
  assign w_sel_digit  = !i_clear && !i_commit && !i_backspace && i_digit_valid;
  assign w_expired    = (r_state == DONE) && (r_timer == LAST);

  // State and datapath register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state          <= IDLE;
      r_code           <= BLANK;
      r_count          <= 3'd0;
      r_full           <= 1'b0;
      r_reject         <= 1'b0;
      r_commit_valid   <= 1'b0;
      r_committed_code <= 28'h0000000;
      r_timer          <= '0;
    end else begin
      r_state          <= w_state_next;
      r_code           <= w_code_next;
      r_count          <= w_count_next;
      r_full           <= (w_count_next == 3'd7);
      r_reject         <= w_reject_next;
      r_commit_valid   <= w_commit_valid_next;
      r_committed_code <= w_committed_next;
      r_timer          <= w_timer_next;
    end
  end

  // Next-state decode: clear always wins, DONE leaves only on expiry.
  always_comb begin
    w_state_next = r_state;
    if (w_sel_clear) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_sel_digit && (i_digit <= 4'd9)) w_state_next = ENTRY;
        end
        ENTRY: begin
          if (w_sel_commit) begin
            w_state_next = DONE;
          end else if (w_sel_bs && (r_count == 3'd1)) begin
            w_state_next = IDLE;
          end
        end
        DONE: begin
          if (w_expired) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the hold timer.
  always_comb begin
    w_code_next         = r_code;
    w_count_next        = r_count;
    w_reject_next       = 1'b0;
    w_commit_valid_next = 1'b0;
    w_committed_next    = r_committed_code;
    w_timer_next        = r_timer;
    if (w_sel_clear) begin
      w_code_next  = BLANK;
      w_count_next = 3'd0;
      w_timer_next = '0;
    end else if (r_state == DONE) begin
      w_reject_next = w_sel_commit || w_sel_bs || w_sel_digit;
      if (w_expired) begin
        w_code_next  = BLANK;
        w_count_next = 3'd0;
        w_timer_next = '0;
      end else begin
        w_timer_next = r_timer + TW'(1);
      end
    end else if (w_sel_commit) begin
      if (r_state == ENTRY) begin
        w_committed_next    = r_code;
        w_commit_valid_next = 1'b1;
        w_timer_next        = '0;
      end else begin
        w_reject_next = 1'b1;
      end
    end else if (w_sel_bs) begin
      if (r_count == 3'd0) begin
        w_reject_next = 1'b1;
      end else begin
        w_code_next  = {4'hA, r_code[27:4]};
        w_count_next = r_count - 3'd1;
      end
    end else if (w_sel_digit) begin
      if ((i_digit > 4'd9) || (r_count == 3'd7)) begin
        w_reject_next = 1'b1;
      end else begin
        w_code_next  = {r_code[23:0], i_digit};
        w_count_next = r_count + 3'd1;
      end
    end
  end

  assign o_code           = r_code;
  assign o_count          = r_count;
  assign o_full           = r_full;
  assign o_reject         = r_reject;
  assign o_commit_valid   = r_commit_valid;
  assign o_committed_code = r_committed_code;

endmodule

// File: doc/bcd_entry.md
BCD_ENTRY -- requirements
Module: bcd_entry

Interface
REQ-001 Parameter: HOLD_CYCLES, default 50_000_000, number of cycles the DONE state holds a committed code before blanking.
REQ-002 CLK  in  1  single system clock; all state updates on rising edge.
REQ-003 RST_N  in  1  reset; synchronous, active-low.
REQ-004 digit_valid  in  1  one-cycle strobe; digit is offered this cycle.
REQ-005 digit  in  4  BCD value 0-9 offered with digit_valid.
REQ-006 backspace  in  1  one-cycle strobe; remove most recently entered digit.
REQ-007 clear  in  1  one-cycle strobe; discard all entered digits.
REQ-008 commit  in  1  one-cycle strobe; finalize entered digits.
REQ-009 code  out  28  seven packed 4-bit display codes: code[3:0] is digit 0 (rightmost), code[27:24] is digit 6; 4'hA = blank/dash.
REQ-010 count  out  3  number of digits currently entered, 0-7.
REQ-011 full  out  1  high when count == 7.
REQ-012 reject  out  1  one-cycle pulse when a strobe is refused.
REQ-013 commit_valid  out  1  one-cycle pulse when a commit is accepted.
REQ-014 committed_code  out  28  value of code captured at the last accepted commit.

Function
REQ-015 The FSM SHALL have three states: IDLE (count 0), ENTRY (1-7 digits), DONE (committed, display held).
REQ-016 Every output SHALL be registered; an accepted strobe at edge N SHALL be visible on the outputs after edge N (one-cycle latency).
REQ-017 Strobe priority within one cycle: clear > commit > backspace > digit_valid; lower-priority strobes in that cycle are ignored without reject.
REQ-018 Accepted digit: code <= {code[23:0], digit}, count +1; IDLE -> ENTRY.
REQ-019 digit_valid with digit > 9 SHALL be refused: code/count unchanged, reject pulses.
REQ-020 digit_valid when full SHALL be refused: code unchanged, count stays 7, reject pulses.
REQ-021 Accepted backspace: code <= {4'hA, code[27:4]}, count -1; count reaching 0 -> IDLE.
REQ-022 backspace in IDLE SHALL be refused with reject pulse.
REQ-023 Accepted commit (ENTRY only): committed_code <= code, commit_valid pulses one cycle, state -> DONE, hold timer loads 0.
REQ-024 commit in IDLE SHALL be refused with reject pulse.
REQ-025 In DONE: code, count and committed_code SHALL hold; digit_valid, backspace and commit are refused with reject pulse.
REQ-026 In DONE the hold timer increments every cycle; the cycle it reaches HOLD_CYCLES-1, state -> IDLE, code <= 28'hAAAAAAA, count <= 0.
REQ-027 Timer width SHALL be $clog2(HOLD_CYCLES)+1 bits; no wrap occurs before expiry.
REQ-028 clear from any state: code <= 28'hAAAAAAA, count <= 0, state -> IDLE, timer cleared; committed_code unchanged; never rejected.
REQ-029 full SHALL equal (count == 7) at all times, including in DONE.
REQ-030 reject and commit_valid SHALL never be high in the same cycle.

Reset
REQ-031 When RST_N is low at a rising edge: state IDLE, code 28'hAAAAAAA, count 0, full 0, reject 0, commit_valid 0, committed_code 28'h0000000, timer 0.
REQ-032 Reset SHALL override all strobes in the same cycle and abort any entry or DONE hold mid-operation.

Verification
REQ-033 Reset, enter 1,2,3 -> code 28'hAAAA123, count 3, no reject.
REQ-034 Enter 1-7, then digit 8 -> code 28'h1234567, full 1, reject one pulse; backspace -> code 28'hA123456, count 6, full 0.
REQ-035 Enter 4,2, commit -> commit_valid one pulse, committed_code 28'hAAAAA42, DONE; digit 5 -> reject, code unchanged; after HOLD_CYCLES (e.g. param 8) -> code 28'hAAAAAAA, count 0, committed_code still 28'hAAAAA42.
REQ-036 digit 4'hB, backspace in IDLE, commit in IDLE -> three reject pulses, code 28'hAAAAAAA.
REQ-037 Same cycle clear+commit+digit_valid in ENTRY -> code blanked, count 0, no commit_valid, no reject.
REQ-038 RST_N low mid-DONE with digit_valid high -> reset values next cycle, committed_code 0.
